// File: rtl/uart_fifo_tx.sv
// +--------------------------------------------------------------------------+
// | uart_fifo_tx: pops 16-bit words from a FIFO and sends each as two 8N1   |
// | frames, low byte first. Define UART_TX_PARITY_EN to add even parity.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_fifo_tx #(
  parameter int CLK_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_fifo_empty,
  output logic        o_fifo_read_req,
  input  logic        i_fifo_read_ack,
  input  logic [15:0] i_fifo_data,
  output logic        o_txd,
  output logic        o_busy
);

  localparam int                  c_BAUD_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_req,   w_req_nxt;
  logic                r_busy,  w_busy_nxt;
  logic                r_txd,   w_txd_nxt;
  logic [15:0]         r_shift, w_shift_nxt;
  logic                r_idx,   w_idx_nxt;
  logic [2:0]          r_bit,   w_bit_nxt;
  logic [c_BAUD_W-1:0] r_baud,  w_baud_nxt;
  logic                w_bit_end;
  logic                w_line;
`ifdef UART_TX_PARITY_EN
  logic                r_par,   w_par_nxt;
`endif

  assign w_bit_end = (r_baud == c_BAUD_LAST);
  assign w_line    = (r_state != S_IDLE) && (r_state != S_FETCH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_txd   <= 1'b1;
      r_shift <= '0;
      r_idx   <= 1'b0;
      r_bit   <= '0;
      r_baud  <= '0;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_busy  <= w_busy_nxt;
      r_txd   <= w_txd_nxt;
      r_shift <= w_shift_nxt;
      r_idx   <= w_idx_nxt;
      r_bit   <= w_bit_nxt;
      r_baud  <= w_baud_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  // Every output is computed one cycle ahead so that it is registered.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_busy_nxt  = r_busy;
    w_txd_nxt   = r_txd;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_bit_nxt   = r_bit;
    w_baud_nxt  = '0;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_txd_nxt  = 1'b1;
        w_busy_nxt = 1'b0;
        w_req_nxt  = 1'b0;
        if (!i_fifo_empty) begin
          w_state_nxt = S_FETCH;
          w_req_nxt   = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      S_FETCH: begin
        if (i_fifo_read_ack) begin
          w_shift_nxt = i_fifo_data;
          w_req_nxt   = 1'b0;
          w_idx_nxt   = 1'b0;
          w_txd_nxt   = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_txd_nxt   = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[15:1]};
          w_bit_nxt   = '0;
          w_state_nxt = S_DATA;
`ifdef UART_TX_PARITY_EN
          w_par_nxt   = r_shift[0];
`endif
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_txd_nxt   = r_par;
            w_state_nxt = S_PARITY;
`else
            w_txd_nxt   = 1'b1;
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt   = r_bit + 3'd1;
            w_txd_nxt   = r_shift[0];
            w_shift_nxt = {1'b0, r_shift[15:1]};
`ifdef UART_TX_PARITY_EN
            w_par_nxt   = r_par ^ r_shift[0];
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_txd_nxt   = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          // After the low byte the high byte sits in r_shift[7:0] already.
          if (!r_idx) begin
            w_idx_nxt   = 1'b1;
            w_txd_nxt   = 1'b0;
            w_state_nxt = S_START;
          end else begin
            w_txd_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_txd_nxt   = 1'b1;
        w_req_nxt   = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
    if (w_line) begin
      w_baud_nxt = w_bit_end ? '0 : r_baud + 1'b1;
    end
  end

  assign o_fifo_read_req = r_req;
  assign o_busy          = r_busy;
  assign o_txd           = r_txd;

endmodule

`default_nettype wire

// File: tb/tb_uart_fifo_tx.sv
// +--------------------------------------------------------------------------+
// | tb_uart_fifo_tx: directed bench for uart_fifo_tx with a per-cycle txd    |
// | scoreboard. Revision: 1.0                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_fifo_tx;

  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int WORD_CYC = 2 * F * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_fifo_empty;
  logic        o_fifo_read_req;
  logic        i_fifo_read_ack;
  logic [15:0] i_fifo_data;
  logic        o_txd;
  logic        o_busy;

  int   n_vec  = 0;
  int   n_fail = 0;
  logic exp_q[$];

  uart_fifo_tx #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_fifo_empty    (i_fifo_empty),
    .o_fifo_read_req (o_fifo_read_req),
    .i_fifo_read_ack (i_fifo_read_ack),
    .i_fifo_data     (i_fifo_data),
    .o_txd           (o_txd),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push_bit(input logic b);
    for (int i = 0; i < CLK_DIV; i++) exp_q.push_back(b);
  endtask

  // Model: start, 8 data LSB first, optional even parity, stop; low byte first.
  task automatic push_word(input logic [15:0] w);
    logic [7:0] byt;
    for (int k = 0; k < 2; k++) begin
      byt = (k == 0) ? w[7:0] : w[15:8];
      push_bit(1'b0);
      for (int i = 0; i < 8; i++) push_bit(byt[i]);
`ifdef UART_TX_PARITY_EN
      push_bit(^byt);
`endif
      push_bit(1'b1);
    end
  endtask

  task automatic play(input int n);
    logic e;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 1'bx;
      check("txd_bit", o_txd, e);
      check("busy_frame", o_busy, 1'b1);
      check("req_frame", o_fifo_read_req, 1'b0);
      tick();
    end
  endtask

  task automatic expect_req();
    tick();
    check("req_rise", o_fifo_read_req, 1'b1);
    check("busy_rise", o_busy, 1'b1);
    check("txd_fetch", o_txd, 1'b1);
  endtask

  task automatic start_word(input logic [15:0] w, input int delay);
    push_word(w);
    for (int i = 1; i < delay; i++) begin
      check("req_hold", o_fifo_read_req, 1'b1);
      check("txd_wait", o_txd, 1'b1);
      check("busy_wait", o_busy, 1'b1);
      tick();
    end
    i_fifo_read_ack = 1'b1;
    i_fifo_data     = w;
    tick();
    i_fifo_read_ack = 1'b0;
    i_fifo_data     = 16'h0000;
    check("req_drop", o_fifo_read_req, 1'b0);
  endtask

  task automatic end_checks();
    check("word_end_busy", o_busy, 1'b0);
    check("word_end_txd", o_txd, 1'b1);
    check("sb_drained", exp_q.size() == 0, 1'b1);
  endtask

  task automatic idle_checks(input int n);
    for (int i = 0; i < n; i++) begin
      check("idle_req", o_fifo_read_req, 1'b0);
      check("idle_txd", o_txd, 1'b1);
      check("idle_busy", o_busy, 1'b0);
      tick();
    end
  endtask

  initial begin
    rst             = 1'b0;
    i_fifo_empty    = 1'b1;
    i_fifo_read_ack = 1'b0;
    i_fifo_data     = 16'h0000;
    tick();
    tick();
    check("rst_txd", o_txd, 1'b1);
    check("rst_req", o_fifo_read_req, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    rst = 1'b1;
    idle_checks(2);

    // Basic word, ack one cycle after the request.
    i_fifo_empty = 1'b0;
    expect_req();
    i_fifo_empty = 1'b1;
    start_word(16'h12a5, 1);
    play(WORD_CYC);
    end_checks();
    idle_checks(3);

    // Delayed ack with the empty flag rising during the wait.
    i_fifo_empty = 1'b0;
    expect_req();
    i_fifo_empty = 1'b1;
    start_word(16'h3c96, 7);
    play(WORD_CYC);
    end_checks();
    idle_checks(2);

    // Back-to-back words.
    i_fifo_empty = 1'b0;
    expect_req();
    start_word(16'h00ff, 1);
    play(WORD_CYC);
    end_checks();
    expect_req();
    i_fifo_empty = 1'b1;
    start_word(16'hff00, 1);
    play(WORD_CYC);
    end_checks();
    idle_checks(3);

    // Stray ack while empty.
    i_fifo_read_ack = 1'b1;
    i_fifo_data     = 16'hbeef;
    tick();
    i_fifo_read_ack = 1'b0;
    i_fifo_data     = 16'h0000;
    idle_checks(6);

    // Reset during the 4th data bit of the low byte.
    i_fifo_empty = 1'b0;
    expect_req();
    i_fifo_empty = 1'b1;
    start_word(16'h5a3c, 1);
    play(4 * CLK_DIV + 2);
    rst = 1'b0;
    tick();
    check("midrst_txd", o_txd, 1'b1);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_req", o_fifo_read_req, 1'b0);
    exp_q.delete();
    rst = 1'b1;
    idle_checks(10);

    // Parity-sensitive word.
    i_fifo_empty = 1'b0;
    expect_req();
    i_fifo_empty = 1'b1;
    start_word(16'h0107, 1);
    play(WORD_CYC);
    end_checks();
    idle_checks(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
